// File: rtl/ysyx_25030081_idu.sv
// Instruction decode stage: picks the immediate format from the opcode,
// builds the immediate through ysyx_25030081_ext and registers the decoded
// entry behind a valid/ready handshake.
// Optional feature macro: YSYX_25030081_IDU_SKID_EN adds a second (skid)
// entry so that in_ready is registered and has no path from out_ready.

// Immediate generator: inst holds instruction bits [31:7].
module ysyx_25030081_ext #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [24:0]           inst,
  input  logic [2:0]            extOp,
  output logic [DATA_WIDTH-1:0] imm
);

  logic [31:0] imm32_s;

  // Assemble the 32-bit immediate of the selected format (bit k of the
  // instruction sits at inst[k-7]).
  always_comb begin
    imm32_s = 32'd0;
    case (extOp)
      3'b000:  imm32_s = {{20{inst[24]}}, inst[24:13]};
      3'b001:  imm32_s = {{20{inst[24]}}, inst[24:18], inst[4:0]};
      3'b010:  imm32_s = {{20{inst[24]}}, inst[0], inst[23:18], inst[4:1], 1'b0};
      3'b011:  imm32_s = {inst[24:5], 12'd0};
      3'b100:  imm32_s = {{12{inst[24]}}, inst[12:5], inst[13], inst[23:14], 1'b0};
      default: imm32_s = 32'd0;
    endcase
  end

  assign imm = DATA_WIDTH'($signed(imm32_s));

endmodule

module ysyx_25030081_idu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [DATA_WIDTH-1:0] in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_inst,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [2:0]            out_ext_op,
  output logic                  out_illegal
);

  // Entry layout, LSB first: illegal, ext_op[2:0], imm, pc, inst.
  localparam int EW = 2 * DATA_WIDTH + 36;

  logic [2:0]            extOp_s;
  logic                  immEn_s;
  logic                  illegal_s;
  logic [DATA_WIDTH-1:0] extImm_s;
  logic [DATA_WIDTH-1:0] decImm_s;
  logic [EW-1:0]         decEntry_s;
  logic [EW-1:0]         outEntry_r;
  logic [EW-1:0]         outEntryNxt_s;
  logic                  outValid_r;
  logic                  outValidNxt_s;
  logic                  loadOut_s;
  logic                  inReady_s;
  logic                  inFire_s;

  // Opcode classification: immediate format, immediate enable, illegal flag.
  always_comb begin
    extOp_s   = 3'b000;
    immEn_s   = 1'b0;
    illegal_s = 1'b0;
    case (in_inst[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
        extOp_s = 3'b000;
        immEn_s = 1'b1;
      end
      7'b0100011: begin
        extOp_s = 3'b001;
        immEn_s = 1'b1;
      end
      7'b1100011: begin
        extOp_s = 3'b010;
        immEn_s = 1'b1;
      end
      7'b0110111, 7'b0010111: begin
        extOp_s = 3'b011;
        immEn_s = 1'b1;
      end
      7'b1101111: begin
        extOp_s = 3'b100;
        immEn_s = 1'b1;
      end
      7'b0110011: begin
        extOp_s = 3'b000;
        immEn_s = 1'b0;
      end
      default: begin
        extOp_s   = 3'b000;
        immEn_s   = 1'b0;
        illegal_s = 1'b1;
      end
    endcase
  end

  ysyx_25030081_ext #(.DATA_WIDTH(DATA_WIDTH)) uExt (
    .inst  (in_inst[31:7]),
    .extOp (extOp_s),
    .imm   (extImm_s)
  );

  // R-type and illegal opcodes carry no immediate.
  assign decImm_s   = immEn_s ? extImm_s : {DATA_WIDTH{1'b0}};
  assign decEntry_s = {in_inst, in_pc, decImm_s, extOp_s, illegal_s};
  assign inFire_s   = in_valid && inReady_s && !flush;
  assign in_ready   = inReady_s;

`ifdef YSYX_25030081_IDU_SKID_EN
  logic [EW-1:0] skidEntry_r;
  logic          skidValid_r;
  logic          skidValidNxt_s;
  logic          loadSkid_s;

  // Ready is simply "skid slot free"; reset and flush override it.
  assign inReady_s = rst_n && (flush || !skidValid_r);

  // Two-entry control: refill the output slot from skid first, else from input.
  always_comb begin
    outValidNxt_s  = outValid_r;
    outEntryNxt_s  = decEntry_s;
    loadOut_s      = 1'b0;
    skidValidNxt_s = skidValid_r;
    loadSkid_s     = 1'b0;
    if (flush) begin
      outValidNxt_s  = 1'b0;
      skidValidNxt_s = 1'b0;
    end else if (!outValid_r || out_ready) begin
      if (skidValid_r) begin
        outEntryNxt_s  = skidEntry_r;
        loadOut_s      = 1'b1;
        outValidNxt_s  = 1'b1;
        skidValidNxt_s = 1'b0;
      end else if (inFire_s) begin
        loadOut_s     = 1'b1;
        outValidNxt_s = 1'b1;
      end else begin
        outValidNxt_s = 1'b0;
      end
    end else begin
      if (inFire_s) begin
        loadSkid_s     = 1'b1;
        skidValidNxt_s = 1'b1;
      end else begin
        skidValidNxt_s = skidValid_r;
      end
    end
  end

  // Skid slot: holds an entry accepted while the output slot is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skidValid_r <= 1'b0;
      skidEntry_r <= {EW{1'b0}};
    end else begin
      skidValid_r <= skidValidNxt_s;
      if (loadSkid_s) begin
        skidEntry_r <= decEntry_s;
      end
    end
  end
`else
  // Single entry: accept whenever the output slot is empty or draining.
  assign inReady_s = rst_n && (flush || !outValid_r || out_ready);

  // Single-entry control: a new entry replaces the output one with no bubble.
  always_comb begin
    outValidNxt_s = outValid_r;
    outEntryNxt_s = decEntry_s;
    loadOut_s     = 1'b0;
    if (flush) begin
      outValidNxt_s = 1'b0;
    end else if (!outValid_r || out_ready) begin
      outValidNxt_s = inFire_s;
      loadOut_s     = inFire_s;
    end else begin
      outValidNxt_s = outValid_r;
    end
  end
`endif

  // Output slot: valid flag plus decoded entry, cleared to zero by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_r <= 1'b0;
      outEntry_r <= {EW{1'b0}};
    end else begin
      outValid_r <= outValidNxt_s;
      if (loadOut_s) begin
        outEntry_r <= outEntryNxt_s;
      end
    end
  end

  assign out_valid   = outValid_r;
  assign out_inst    = outEntry_r[EW-1 -: 32];
  assign out_pc      = outEntry_r[EW-33 -: DATA_WIDTH];
  assign out_imm     = outEntry_r[DATA_WIDTH+3 -: DATA_WIDTH];
  assign out_ext_op  = outEntry_r[3:1];
  assign out_illegal = outEntry_r[0];

endmodule

// File: tb/tb_ysyx_25030081_idu.sv
// Bench for ysyx_25030081_idu: a queue-based model of held entries is
// compared against the DUT on every falling edge, with directed scenarios
// that also check hand-computed literal values.
module tb_ysyx_25030081_idu;

`ifdef YSYX_25030081_IDU_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_inst, in_pc, out_inst, out_pc, out_imm;
  logic [2:0]  out_ext_op;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  op;
    logic        ill;
  } ent_t;

  ent_t q[$];
  int   popCycle[$];
  int   nChecks = 0;
  int   nFail = 0;
  int   cycle = 0;
  logic rdyNow;

  ysyx_25030081_idu #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_imm(out_imm), .out_ext_op(out_ext_op), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Decode straight from the RISC-V immediate definitions.
  function automatic ent_t model(input logic [31:0] i, input logic [31:0] p);
    ent_t e;
    e.inst = i; e.pc = p; e.imm = 32'd0; e.op = 3'd0; e.ill = 1'b0;
    case (i[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: e.imm = 32'($signed(i[31:20]));
      7'h23: begin e.op = 3'd1; e.imm = 32'($signed({i[31:25], i[11:7]})); end
      7'h63: begin e.op = 3'd2; e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
      7'h37, 7'h17: begin e.op = 3'd3; e.imm = {i[31:12], 12'd0}; end
      7'h6F: begin e.op = 3'd4; e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
      7'h33: e.imm = 32'd0;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Capacity view: one slot, or two with the skid entry.
  function automatic logic expReady();
    if (!rst_n) return 1'b0;
    if (flush) return 1'b1;
    if (SKID) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  // Model update on each rising edge.
  always @(posedge clk) begin
    cycle++;
    if (!rst_n) begin
      q.delete();
    end else begin
      rdyNow = expReady();
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() != 0 && out_ready) begin
          void'(q.pop_front());
          popCycle.push_back(cycle);
        end
        if (in_valid && rdyNow) q.push_back(model(in_inst, in_pc));
      end
    end
  end

  // Compare process on every falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_imm", out_imm, 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_inst", out_inst, 32'd0);
      chk("rst_out_ext_op", {29'd0, out_ext_op}, 32'd0);
      chk("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
    end else begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, expReady()});
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      if (q.size() != 0) begin
        chk("out_inst", out_inst, q[0].inst);
        chk("out_pc", out_pc, q[0].pc);
        chk("out_imm", out_imm, q[0].imm);
        chk("out_ext_op", {29'd0, out_ext_op}, {29'd0, q[0].op});
        chk("out_illegal", {31'd0, out_illegal}, {31'd0, q[0].ill});
      end
    end
  end

  task automatic sendOne(input logic [31:0] i, input logic [31:0] p, input logic [2:0] op,
                         input logic [31:0] imm, input logic ill);
    ent_t e;
    in_valid = 1'b1; in_inst = i; in_pc = p; out_ready = 1'b1; flush = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("fmt_valid", {31'd0, out_valid}, 32'd1);
    chk("fmt_pc", out_pc, p);
    chk("fmt_ext_op", {29'd0, out_ext_op}, {29'd0, op});
    chk("fmt_imm", out_imm, imm);
    chk("fmt_illegal", {31'd0, out_illegal}, {31'd0, ill});
    e = model(i, p);
    chk("model_imm", e.imm, imm);
    chk("model_op", {29'd0, e.op}, {29'd0, op});
    chk("model_ill", {31'd0, e.ill}, {31'd0, ill});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b2b[8];
    int idx, base, popBase;
    logic acc;
    b2b = '{32'hFFF00093, 32'h00112623, 32'hFE000EE3, 32'h123450B7,
            32'h0080006F, 32'h00B50533, 32'h00000000, 32'h00000013};
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'd0; in_pc = 32'd0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // Immediate formats; the first one also checks transfer on the first edge after reset.
    sendOne(32'hFFF00093, 32'h80000000, 3'd0, 32'hFFFFFFFF, 1'b0);
    sendOne(32'h00112623, 32'h80000004, 3'd1, 32'h0000000C, 1'b0);
    sendOne(32'hFE000EE3, 32'h80000008, 3'd2, 32'hFFFFFFFC, 1'b0);
    sendOne(32'h123450B7, 32'h8000000C, 3'd3, 32'h12345000, 1'b0);
    sendOne(32'h0080006F, 32'h80000010, 3'd4, 32'h00000008, 1'b0);
    sendOne(32'h00000000, 32'h80000014, 3'd0, 32'h00000000, 1'b1);
    sendOne(32'h00B50533, 32'h80000018, 3'd0, 32'h00000000, 1'b0);

    // Backpressure and ordering.
    idx = 0;
    popBase = popCycle.size();
    for (int c = 0; c < 12; c++) begin
      out_ready = (c >= 3);
      in_valid = (idx < 3);
      in_pc = 32'h80000000 + 32'(4 * idx);
      in_inst = 32'h00000093 | (32'(idx) << 20);
      #1;
      acc = in_valid && in_ready;
      if (c == 1) chk("bp_ready_after_first", {31'd0, in_ready}, {31'd0, SKID});
      if (c == 2) chk("bp_ready_after_second", {31'd0, in_ready}, 32'd0);
      if (c >= 1 && c <= 3) chk("bp_frozen_pc", out_pc, 32'h80000000);
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("bp_pop_count", 32'(popCycle.size() - popBase), 32'd3);

    // Back-to-back stream.
    base = popCycle.size();
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      in_pc = 32'h00001000 + 32'(4 * k);
      in_inst = b2b[k];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_count", 32'(popCycle.size() - base), 32'd8);
    if (popCycle.size() >= base + 8) begin
      for (int k = 1; k < 8; k++)
        chk("b2b_consecutive", 32'(popCycle[base + k] - popCycle[base + k - 1]), 32'd1);
    end

    // Flush with an entry stalled (and a skid entry when present).
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 32'h00002000;
    @(posedge clk); #1;
    in_pc = 32'h00002004;
    @(posedge clk); #1;
    chk("fl_valid_before", {31'd0, out_valid}, 32'd1);
    flush = 1'b1; in_pc = 32'h00002008;
    #1 chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid_after", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset during a stall.
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h00003000; in_inst = 32'h00112623;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    chk("ar_valid_before", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_valid_immediate", {31'd0, out_valid}, 32'd0);
    chk("ar_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1; in_valid = 1'b1; in_pc = 32'h00003004; in_inst = 32'h0080006F;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("ar_resume_valid", {31'd0, out_valid}, 32'd1);
    chk("ar_resume_pc", out_pc, 32'h00003004);
    chk("ar_resume_imm", out_imm, 32'h00000008);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("final_drained", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
